// File: rtl/dpi_event_queue_if.sv
// Drain port of the event queue: show-ahead head entry with a valid/ready handshake.
//   ev_valid  head entry available
//   ev_ready  consumer accepts head
//   ev_chan   head channel index
//   ev_stage  stage latched at detection
//   ev_time   timestamp latched at detection
// The master modport is the queue. The slave modport is the DPI-C bridge.
interface dpi_event_queue_if #(
    parameter int unsigned CH_W    = 4,
    parameter int unsigned STAGE_W = 3,
    parameter int unsigned TS_W    = 32
);
    logic               ev_valid;
    logic               ev_ready;
    logic [CH_W-1:0]    ev_chan;
    logic [STAGE_W-1:0] ev_stage;
    logic [TS_W-1:0]    ev_time;

    modport master (
        output ev_valid,
        output ev_chan,
        output ev_stage,
        output ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_chan,
        input  ev_stage,
        input  ev_time,
        output ev_ready
    );
endinterface

// File: rtl/dpi_event_queue.sv
// Clocked event adapter for the DPI-C bridge.
// The block detects rising edges on NUM_CH level-type simulation signals. It also detects changes
// of the processor stage on pseudo-channel NUM_CH, when STAGE_EVT is set. Each event is stamped
// with the cycle timestamp and the stage. It is held in a per-channel pending slot and then
// pushed through a fixed-priority arbiter into a DEPTH-entry show-ahead FIFO.
// A rise on a channel that is already pending and is not being pushed is merged into drop_cnt_o.
//   clk, rst_n     clock, asynchronous active-low reset
//   ch_level_i     event levels, bit i = channel i
//   ch_mask_i      1 = channel enabled
//   stage_i        current processor stage
//   ev_if          drain port (master)
//   count_o        FIFO occupancy
//   drop_cnt_o     saturating count of merged events
module dpi_event_queue #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned STAGE_W   = 3,
    parameter int unsigned STAGE_EVT = 1,
    parameter int unsigned CH_W      = $clog2(NUM_CH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_level_i,
    input  logic [NUM_CH-1:0]          ch_mask_i,
    input  logic [STAGE_W-1:0]         stage_i,
    dpi_event_queue_if.master          ev_if,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned NumSrc = NUM_CH + ((STAGE_EVT != 0) ? 1 : 0);
    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned MrgW   = $clog2(NumSrc + 1);

    typedef struct packed {
        logic [CH_W-1:0]    chan;
        logic [STAGE_W-1:0] stage;
        logic [TS_W-1:0]    ts;
    } entry_t;

    logic [TS_W-1:0]    ts_q;
    logic [NUM_CH-1:0]  lvl_q;
    logic [NUM_CH-1:0]  lvl_rise;
    logic [NumSrc-1:0]  rise;
    logic [NumSrc-1:0]  pend_q, pend_d;
    logic [TS_W-1:0]    cap_ts_q    [NumSrc];
    logic [TS_W-1:0]    cap_ts_d    [NumSrc];
    logic [STAGE_W-1:0] cap_stage_q [NumSrc];
    logic [STAGE_W-1:0] cap_stage_d [NumSrc];
    logic [15:0]        drop_q, drop_d;
    logic [MrgW-1:0]    merge_n;
    logic [16:0]        drop_sum;

    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_idx;
    logic               push, pop, full;
    entry_t             mem_q [DEPTH];
    entry_t             wdata, head;
    logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]     count_q, count_d;

    assign lvl_rise = ch_level_i & ~lvl_q & ch_mask_i;

    if (STAGE_EVT != 0) begin : g_stage
        logic [STAGE_W-1:0] stage_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_q <= '0;
            else        stage_q <= stage_i;
        end
        // The stage pseudo-channel is the top index, so it has the lowest priority.
        assign rise = {stage_i != stage_q, lvl_rise};
    end else begin : g_no_stage
        assign rise = lvl_rise;
    end

    // Fixed priority: scan from the top down so that the lowest pending index is kept.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end

    assign full  = (count_q == (AddrW + 1)'(DEPTH));
    assign pop   = ev_if.ev_valid & ev_if.ev_ready;
    assign push  = gnt_vld & (~full | pop);
    assign wdata = '{chan: gnt_idx, stage: cap_stage_q[gnt_idx], ts: cap_ts_q[gnt_idx]};

    always_comb begin
        pend_d      = pend_q;
        cap_ts_d    = cap_ts_q;
        cap_stage_d = cap_stage_q;
        merge_n     = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (push && (gnt_idx == CH_W'(i))) pend_d[i] = 1'b0;
            if (rise[i]) begin
                // A slot that empties this cycle takes the new rise as a fresh event.
                if (!pend_q[i] || (push && (gnt_idx == CH_W'(i)))) begin
                    pend_d[i]      = 1'b1;
                    cap_ts_d[i]    = ts_q;
                    cap_stage_d[i] = stage_i;
                end else begin
                    merge_n = merge_n + MrgW'(1);
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_q} + 17'(merge_n);
    assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            lvl_q    <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NumSrc; i++) begin
                cap_ts_q[i]    <= '0;
                cap_stage_q[i] <= '0;
            end
        end else begin
            ts_q        <= ts_q + 1'b1;
            lvl_q       <= ch_level_i;
            pend_q      <= pend_d;
            cap_ts_q    <= cap_ts_d;
            cap_stage_q <= cap_stage_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // The storage has no reset. The head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head           = mem_q[rd_ptr_q];
    assign ev_if.ev_valid = (count_q != '0);
    assign ev_if.ev_chan  = ev_if.ev_valid ? head.chan  : '0;
    assign ev_if.ev_stage = ev_if.ev_valid ? head.stage : '0;
    assign ev_if.ev_time  = ev_if.ev_valid ? head.ts    : '0;
    assign count_o        = count_q;
    assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_dpi_event_queue.sv
// Directed bench for dpi_event_queue with NUM_CH=8, DEPTH=16, STAGE_EVT=1.
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the same point.
// cyc counts the rising edges since reset release. An input driven while cyc == n is detected at
// the next edge, so its timestamp is n.
module tb_dpi_event_queue;

    localparam int unsigned NumCh  = 8;
    localparam int unsigned Depth  = 16;
    localparam int unsigned TsW    = 32;
    localparam int unsigned StageW = 3;
    localparam int unsigned ChW    = 4;
    localparam int unsigned StgCh  = 8;

    logic              clk;
    logic              rst_n;
    logic [NumCh-1:0]  ch_level;
    logic [NumCh-1:0]  ch_mask;
    logic [StageW-1:0] stage;
    logic [4:0]        count;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0, w1, w2, w3, s0;

    dpi_event_queue_if #(.CH_W(ChW), .STAGE_W(StageW), .TS_W(TsW)) ev_if ();

    dpi_event_queue #(
        .NUM_CH   (NumCh),
        .DEPTH    (Depth),
        .TS_W     (TsW),
        .STAGE_W  (StageW),
        .STAGE_EVT(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_level_i(ch_level),
        .ch_mask_i (ch_mask),
        .stage_i   (stage),
        .ev_if     (ev_if),
        .count_o   (count),
        .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_head(input string tag, input int chan, input int tm, input int stg);
        check_eq({tag, ".valid"}, 32'(ev_if.ev_valid), 32'd1);
        check_eq({tag, ".chan"},  32'(ev_if.ev_chan),  32'(chan));
        check_eq({tag, ".time"},  ev_if.ev_time,       32'(tm));
        check_eq({tag, ".stage"}, 32'(ev_if.ev_stage), 32'(stg));
    endtask

    initial begin
        rst_n          = 1'b0;
        ch_level       = '0;
        ch_mask        = '1;
        stage          = '0;
        ev_if.ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("in_reset.valid", 32'(ev_if.ev_valid), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;

        // Idle after reset release: nothing is produced and every output keeps its reset value.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle.valid", 32'(ev_if.ev_valid), 32'd0);
            check_eq("idle.count", 32'(count), 32'd0);
            check_eq("idle.drop",  32'(drop_cnt), 32'd0);
        end
        check_eq("idle.chan",  32'(ev_if.ev_chan), 32'd0);
        check_eq("idle.stage", 32'(ev_if.ev_stage), 32'd0);
        check_eq("idle.time",  ev_if.ev_time, 32'd0);

        // Single event on ch 2. The latency is two edges and the pop takes one cycle.
        ev_if.ev_ready = 1'b1;
        t0 = cyc;
        ch_level = 8'h04;
        tick();
        check_eq("single.lat1", 32'(ev_if.ev_valid), 32'd0);
        ch_level = 8'h00;
        tick();
        check_head("single", 2, t0, 0);
        check_eq("single.count1", 32'(count), 32'd1);
        tick();
        check_eq("single.popped", 32'(ev_if.ev_valid), 32'd0);
        check_eq("single.count0", 32'(count), 32'd0);

        // ch 0, 3 and 7 rise together. They drain in index order, one per cycle.
        t0 = cyc;
        ch_level = 8'h89;
        tick();
        ch_level = 8'h00;
        tick();
        check_head("multi0", 0, t0, 0);
        tick();
        check_head("multi3", 3, t0, 0);
        tick();
        check_head("multi7", 7, t0, 0);
        tick();
        check_eq("multi.empty", 32'(ev_if.ev_valid), 32'd0);

        // A masked channel produces nothing.
        ch_mask  = 8'hDF;
        ch_level = 8'h20;
        repeat (3) tick();
        check_eq("mask.valid", 32'(ev_if.ev_valid), 32'd0);
        check_eq("mask.count", 32'(count), 32'd0);
        ch_level = 8'h00;
        tick();
        ch_mask = 8'hFF;

        // Back-pressure: 16 entries fill the FIFO, 4 more stay pending and 2 rises merge.
        ev_if.ev_ready = 1'b0;
        w1 = cyc;
        ch_level = 8'hFF;
        tick();
        ch_level = 8'h00;
        repeat (11) tick();
        w2 = cyc;
        ch_level = 8'hFF;
        tick();
        ch_level = 8'h00;
        repeat (11) tick();
        check_eq("fill.count16", 32'(count), 32'd16);
        w3 = cyc;
        ch_level = 8'h0F;
        tick();
        ch_level = 8'h00;
        tick();
        ch_level = 8'h03;
        tick();
        ch_level = 8'h00;
        tick();
        check_eq("full.count", 32'(count), 32'd16);
        check_eq("full.drop",  32'(drop_cnt), 32'd2);
        check_head("full.head", 0, w1, 0);
        tick();
        check_head("full.stable", 0, w1, 0);
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_eq("drain.chan", 32'(ev_if.ev_chan), 32'(i % 8));
            check_eq("drain.time", ev_if.ev_time, 32'((i < 8) ? w1 : ((i < 16) ? w2 : w3)));
            check_eq("drain.valid", 32'(ev_if.ev_valid), 32'd1);
            tick();
        end
        check_eq("drain.empty", 32'(ev_if.ev_valid), 32'd0);
        check_eq("drain.count", 32'(count), 32'd0);
        check_eq("drain.drop",  32'(drop_cnt), 32'd2);

        // Stage changes with ch 1. The ch 1 event comes before each stage event.
        s0 = cyc;
        stage    = 3'd1;
        ch_level = 8'h02;
        tick();
        ch_level = 8'h00;
        tick();
        check_head("stg.c1a", 1, s0, 1);
        stage    = 3'd2;
        ch_level = 8'h02;
        tick();
        check_head("stg.s1", StgCh, s0, 1);
        ch_level = 8'h00;
        tick();
        check_head("stg.c1b", 1, s0 + 2, 2);
        tick();
        check_head("stg.s2", StgCh, s0 + 2, 2);
        tick();
        check_eq("stg.empty", 32'(ev_if.ev_valid), 32'd0);
        check_eq("stg.drop",  32'(drop_cnt), 32'd2);

        // Queue two events, then pulse reset in the middle of a cycle.
        ev_if.ev_ready = 1'b0;
        stage    = 3'd0;
        ch_level = 8'h10;
        repeat (4) tick();
        check_eq("prerst.count", 32'(count), 32'd2);
        ch_level = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst.valid", 32'(ev_if.ev_valid), 32'd0);
        check_eq("rst.count", 32'(count), 32'd0);
        check_eq("rst.drop",  32'(drop_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        ev_if.ev_ready = 1'b1;
        ch_level = 8'h40;
        tick();
        ch_level = 8'h00;
        tick();
        check_head("post", 6, 0, 0);
        check_eq("post.count", 32'(count), 32'd1);
        tick();
        check_eq("post.empty", 32'(ev_if.ev_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpi_event_queue.md
# dpi_event_queue

Parametrised, clocked successor to the simulation event adapter. It samples NUM_CH level-type simulation signals (halt, jal/jalr, mem read/write enable, ecall, …) plus an optional stage-change pseudo-channel, and detects rising edges synchronously. Each event is stamped with a cycle timestamp and the processor stage, then buffered in a DEPTH-entry FIFO. A valid/ready drain port feeds the DPI-C bridge one event per cycle, so back-pressure from the host never loses ordering. Dropped and merged events are counted, never silent.

## Interface
- NUM_CH, 8, number of level-type event channels (≥1)
- DEPTH, 16, FIFO entries, power of two, ≥2
- TS_W, 32, timestamp width
- STAGE_W, 3, processor stage width
- STAGE_EVT, 1, 1 = stage changes generate events on pseudo-channel NUM_CH
- CH_W, derived = $clog2(NUM_CH+1), channel-index width
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- ch_level  in  NUM_CH  event levels; bit i = channel i
- ch_mask  in  NUM_CH  1 = channel enabled
- stage  in  STAGE_W  current processor stage
- ev_valid  out  1  head entry available
- ev_ready  in  1  consumer accepts head
- ev_chan  out  CH_W  head channel index
- ev_stage  out  STAGE_W  stage latched at detection
- ev_time  out  TS_W  timestamp latched at detection
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_cnt  out  16  saturating count of merged/lost events

## Operation
- Free-running cycle counter `ts`: resets to 0, increments every clk, wraps modulo 2^TS_W.
- Edge detect: lvl_q registers ch_level, resetting to 0. rise[i] = ch_level[i] & ~lvl_q[i] & ch_mask[i]. A level already high at reset release produces an event on the first clock.
- Stage event (STAGE_EVT=1): stage_q resets to 0. When stage != stage_q, raise pseudo-channel NUM_CH. No mask applies. With STAGE_EVT=0 this logic is absent and count/arbitration cover NUM_CH channels only.
- Pending bitmap: on rise, set pend[i] and latch ts and stage into per-channel capture regs.
- Arbiter: fixed priority, lowest index wins; the stage pseudo-channel has the lowest priority.
- Each cycle, if any pend is set and push is allowed, the granted entry {chan, stage, time} is written to the FIFO tail and its pend bit is cleared.
- Push allowed = !full | pop.
- Rise on the granted channel in the same cycle: the bit stays set and the capture regs take the new values. This is a new event, not a drop.
- Rise on a pending, non-granted channel: the event merges and the first capture is kept. drop_cnt += number of such channels this cycle, saturating at 0xFFFF.
- Clearing ch_mask does not flush pending bits or FIFO entries.
- FIFO is show-ahead. ev_* is driven from the head whenever ev_valid=1. pop = ev_valid & ev_ready.
- Outputs are stable while ev_valid & !ev_ready.

## Timing
- Reset values: ev_valid=0, ev_chan=0, ev_stage=0, ev_time=0, count=0, drop_cnt=0. pend, lvl_q, stage_q and ts are all 0.
- Latency: ch_level rises before posedge t → pend set at t → entry pushed at t+1 → ev_valid=1 after t+1. Latency is 2 cycles with an empty FIFO and no higher-priority pending channel.
- ev_time = ts value sampled at posedge t, i.e. the cycle of detection.
- Throughput: one push and one pop per cycle.
- Full FIFO: no push unless a pop occurs the same cycle. Pending bits hold and further rises merge into drop_cnt.
- Empty FIFO with simultaneous push: pop is impossible; ev_valid rises the next cycle. There is no fall-through bypass.
- count updates: +1 on push only, −1 on pop only, unchanged on both.
- Reset asserted mid-operation clears FIFO, pending bits and counters immediately (async). Partially drained events are discarded.

## Test plan
- Reset release with ch_level=0, stage=0: no events, and all outputs hold their reset values for 10 cycles.
- Rise ch 2 at cycle 5, ev_ready=1: ev_valid high after cycle 7; ev_chan=2, ev_time=5, ev_stage=current stage; single-cycle pop; count returns to 0.
- Rise ch 0, 3 and 7 at the same cycle t: three events emitted in order 0, 3, 7 on consecutive cycles, all with ev_time=t.
- ev_ready=0 and 20 distinct rises with DEPTH=16: count saturates at 16 and rises beyond the buffer increment drop_cnt. Then ev_ready=1: exactly 16 entries plus the still-pending entries drain in order.
- STAGE_EVT=1, stage 0→1→2 on successive cycles while ch 1 rises simultaneously: ch 1 event precedes each stage event, and the stage events carry stage values 1 and 2.
- Events queued, rst_n pulsed low mid-cycle: ev_valid drops asynchronously, count=0, drop_cnt=0. A new rise after release behaves as the first event.
